// File: rtl/sp_core_if.sv
// sp_core_if: instruction handshake plus data-memory bus of sp_core.
interface sp_core_if #(
    parameter int unsigned MEM_AW = 12
);
    logic              in_valid;
    logic [31:0]       inst;
    logic              out_valid;
    logic [31:0]       inst_addr;
    logic              mem_wen;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Core side: consumes instructions, drives the memory request.
    modport master (
        input  in_valid,
        input  inst,
        input  mem_rdata,
        output out_valid,
        output inst_addr,
        output mem_wen,
        output mem_addr,
        output mem_wdata
    );

    // Environment side: instruction source and data memory.
    modport slave (
        output in_valid,
        output inst,
        output mem_rdata,
        input  out_valid,
        input  inst_addr,
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/sp_core.sv
// sp_core: multi-cycle MIPS-subset core. Executes one handshaken instruction at a time
// against a 32x32 register file and a synchronous-read external data memory.
module sp_core #(
    parameter int unsigned MEM_AW = 12
) (
    input logic       clk,
    input logic       rst,
    sp_core_if.master bus
);

    typedef enum logic [1:0] {StIdle, StExec, StLoad, StDone} state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    state_e      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] r [0:31];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4, ea;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pc_next;
    logic        is_load, is_store;
    logic        unused_ea;

    assign opcode = inst_q[31:26];
    assign rs     = inst_q[25:21];
    assign rt     = inst_q[20:16];
    assign rd     = inst_q[15:11];
    assign shamt  = inst_q[10:6];
    assign funct  = inst_q[5:0];
    assign imm    = inst_q[15:0];
    assign target = inst_q[25:0];

    assign rs_val   = (rs == 5'd0) ? 32'd0 : r[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : r[rt];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    assign pc_plus4 = pc_q + 32'd4;
    assign ea       = rs_val + imm_sext;

    // Only the word-address bits of the effective address reach the memory.
    assign unused_ea = ^{ea[31:MEM_AW+2], ea[1:0]};

    // Decode and execute the latched instruction: ALU result, destination, next PC.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = rd;
        wr_data  = 32'd0;
        pc_next  = pc_plus4;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OpRtype: begin
                wr_en = 1'b1;
                case (funct)
                    FnAdd:   wr_data = rs_val + rt_val;
                    FnSub:   wr_data = rs_val - rt_val;
                    FnAnd:   wr_data = rs_val & rt_val;
                    FnOr:    wr_data = rs_val | rt_val;
                    FnNor:   wr_data = ~(rs_val | rt_val);
                    FnSlt:   wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    FnSll:   wr_data = rt_val << shamt;
                    FnSrl:   wr_data = rt_val >> shamt;
                    FnJr: begin
                        wr_en   = 1'b0;
                        pc_next = rs_val;
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            OpAddi: begin
                wr_en   = 1'b1;
                wr_addr = rt;
                wr_data = rs_val + imm_sext;
            end
            OpAndi: begin
                wr_en   = 1'b1;
                wr_addr = rt;
                wr_data = rs_val & imm_zext;
            end
            OpOri: begin
                wr_en   = 1'b1;
                wr_addr = rt;
                wr_data = rs_val | imm_zext;
            end
            OpSlti: begin
                wr_en   = 1'b1;
                wr_addr = rt;
                wr_data = {31'd0, $signed(rs_val) < $signed(imm_sext)};
            end
            OpLui: begin
                wr_en   = 1'b1;
                wr_addr = rt;
                wr_data = {imm, 16'h0000};
            end
            OpLw:  is_load  = 1'b1;
            OpSw:  is_store = 1'b1;
            OpBeq: begin
                if (rs_val == rt_val) pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
            end
            OpBne: begin
                if (rs_val != rt_val) pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
            end
            OpJ:   pc_next = {pc_plus4[31:28], target, 2'b00};
            OpJal: begin
                wr_en   = 1'b1;
                wr_addr = 5'd31;
                wr_data = pc_plus4;
                pc_next = {pc_plus4[31:28], target, 2'b00};
            end
            default: ;
        endcase
    end

    // Sequencing: accept, execute, optional load wait, commit pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StExec;
            StExec:  state_d = is_load ? StLoad : StDone;
            StLoad:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, instruction latch and PC; PC commits at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= 32'd0;
            inst_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.in_valid) inst_q <= bus.inst;
            if (state_q == StExec) pc_q <= pc_next;
        end
    end

    // Register file: ALU results commit in EXEC, load data in LOAD; r[0] never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r[i] <= 32'd0;
        end else if (state_q == StExec && wr_en && wr_addr != 5'd0) begin
            r[wr_addr] <= wr_data;
        end else if (state_q == StLoad && rt != 5'd0) begin
            r[rt] <= bus.mem_rdata;
        end
    end

    assign bus.out_valid = (state_q == StDone);
    assign bus.inst_addr = pc_q;
    // Reset gates the write so a store caught mid-flight never lands.
    assign bus.mem_wen   = (state_q == StExec) && is_store && !rst;
    assign bus.mem_addr  = ea[MEM_AW+1:2];
    assign bus.mem_wdata = rt_val;

endmodule

// File: tb/tb_sp_core.sv
// tb_sp_core: directed and randomized instruction streams checked against a
// behavioural ISA model of sp_core.
module tb_sp_core;
    localparam int unsigned MemAw = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sp_core_if #(.MEM_AW(MemAw)) bus ();
    sp_core #(.MEM_AW(MemAw)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Environment memory: unwritten words read as a fixed address-derived pattern.
    logic [31:0] tb_mem [4096];
    bit          tb_wr  [4096];
    logic [31:0] ref_mem [4096];
    bit          ref_wr  [4096];
    logic [31:0] ref_r   [32];
    logic [31:0] ref_pc;

    function automatic logic [31:0] mem_init(input int idx);
        return 32'(idx) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] tb_mem_rd(input int idx);
        return tb_wr[idx] ? tb_mem[idx] : mem_init(idx);
    endfunction

    function automatic logic [31:0] ref_mem_rd(input int idx);
        return ref_wr[idx] ? ref_mem[idx] : mem_init(idx);
    endfunction

    // Synchronous-read data memory.
    always @(posedge clk) begin
        bus.mem_rdata <= tb_wr[bus.mem_addr] ? tb_mem[bus.mem_addr] : mem_init(int'(bus.mem_addr));
        if (bus.mem_wen) begin
            tb_mem[bus.mem_addr] <= bus.mem_wdata;
            tb_wr[bus.mem_addr]  <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic model_reset();
        ref_pc = 32'd0;
        for (int i = 0; i < 32; i++) ref_r[i] = 32'd0;
    endtask

    // ISA-level reference: architectural effect of one instruction.
    task automatic model_step(input logic [31:0] ins, output int lat, output int wen,
                              output int st_idx);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dst;
        logic [31:0] a, b, se, ze, npc, ea, res;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
        a  = ref_r[rs];
        b  = ref_r[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        npc = ref_pc + 32'd4;
        ea  = a + se;
        lat = 2; wen = 0; st_idx = -1; dst = 5'd0; res = 32'd0;
        case (op)
            6'h00: case (fn)
                6'h20: begin dst = rd; res = a + b; end
                6'h22: begin dst = rd; res = a - b; end
                6'h24: begin dst = rd; res = a & b; end
                6'h25: begin dst = rd; res = a | b; end
                6'h27: begin dst = rd; res = ~(a | b); end
                6'h2A: begin dst = rd; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h00: begin dst = rd; res = b << sh; end
                6'h02: begin dst = rd; res = b >> sh; end
                6'h08: npc = a;
                default: ;
            endcase
            6'h08: begin dst = rt; res = a + se; end
            6'h0C: begin dst = rt; res = a & ze; end
            6'h0D: begin dst = rt; res = a | ze; end
            6'h0A: begin dst = rt; res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'h0F: begin dst = rt; res = {ins[15:0], 16'h0000}; end
            6'h23: begin lat = 3; dst = rt; res = ref_mem_rd(int'(ea[13:2])); end
            6'h2B: begin
                wen = 1;
                st_idx = int'(ea[13:2]);
                ref_mem[st_idx] = b;
                ref_wr[st_idx]  = 1'b1;
            end
            6'h04: if (a == b) npc = npc + (se << 2);
            6'h05: if (a != b) npc = npc + (se << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            6'h03: begin dst = 5'd31; res = npc; npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: ;
        endcase
        if (dst != 5'd0) ref_r[dst] = res;
        ref_pc = npc;
    endtask

    task automatic check_arch(input string tag);
        check($sformatf("%s pc", tag), bus.inst_addr, ref_pc);
        for (int i = 0; i < 32; i++) check($sformatf("%s r%0d", tag, i), dut.r[i], ref_r[i]);
    endtask

    // Issue one instruction from a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic run_inst(input logic [31:0] ins, input bit busy);
        int lat_exp, wen_exp, st_idx, lat, wen_cnt;
        bus.inst     = ins;
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        if (busy) bus.inst = enc_i(6'h08, 5'd0, 5'd7, 16'h0077);
        else      bus.in_valid = 1'b0;
        model_step(ins, lat_exp, wen_exp, st_idx);
        lat = 1;
        wen_cnt = 0;
        while (!bus.out_valid && lat < 10) begin
            if (bus.mem_wen) wen_cnt++;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check($sformatf("%h latency", ins), 32'(lat), 32'(lat_exp));
        check($sformatf("%h mem_wen cycles", ins), 32'(wen_cnt), 32'(wen_exp));
        check_arch($sformatf("%h", ins));
        if (st_idx >= 0) check($sformatf("%h store", ins), tb_mem_rd(st_idx), ref_mem_rd(st_idx));
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        check($sformatf("%h out_valid gap", ins), 32'(bus.out_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] op, fn;
        if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 9))
                0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h24;  3: fn = 6'h25;
                4: fn = 6'h2A;  5: fn = 6'h27;  6: fn = 6'h00;  7: fn = 6'h02;
                8: fn = 6'h08;  default: fn = 6'h3F;
            endcase
            return enc_r(rand_reg(), rand_reg(), rand_reg(), 5'($urandom), fn);
        end
        case ($urandom_range(0, 11))
            0: op = 6'h08;  1: op = 6'h0C;  2: op = 6'h0D;  3: op = 6'h0A;
            4: op = 6'h0F;  5: op = 6'h23;  6: op = 6'h2B;  7: op = 6'h04;
            8: op = 6'h05;  9: op = 6'h02;  10: op = 6'h03; default: op = 6'h3F;
        endcase
        if (op == 6'h02 || op == 6'h03) return enc_j(op, 26'($urandom));
        return enc_i(op, rand_reg(), rand_reg(), 16'($urandom));
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.inst     = 32'd0;
        model_reset();
        @(negedge clk);

        // Reset state.
        do_reset();
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset mem_wen", 32'(bus.mem_wen), 32'd0);
        check_arch("reset");

        // Reset during EXEC of addi $1,$0,5 aborts it.
        bus.inst = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("abort r1", dut.r[1], 32'd0);
        check("abort pc", bus.inst_addr, 32'd0);
        @(posedge clk); @(negedge clk);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);

        // ALU sequence.
        run_inst(enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD), 1'b0);
        run_inst(enc_i(6'h08, 5'd0, 5'd2, 16'd7), 1'b0);
        run_inst(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h22), 1'b0);
        run_inst(enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h2A), 1'b0);
        run_inst(enc_r(5'd0, 5'd2, 5'd5, 5'd4, 6'h00), 1'b0);
        run_inst(enc_i(6'h0F, 5'd0, 5'd6, 16'h8000), 1'b0);
        run_inst(enc_i(6'h08, 5'd0, 5'd0, 16'd9), 1'b0);
        check("alu r1", dut.r[1], 32'hFFFF_FFFD);
        check("alu r3", dut.r[3], 32'hFFFF_FFF6);
        check("alu r4", dut.r[4], 32'd1);
        check("alu r5", dut.r[5], 32'h70);
        check("alu r6", dut.r[6], 32'h8000_0000);
        check("alu r0", dut.r[0], 32'd0);
        check("alu pc", bus.inst_addr, 32'd28);

        // Store then load through a negative offset.
        run_inst(enc_i(6'h08, 5'd0, 5'd1, 16'h0040), 1'b0);
        run_inst(enc_i(6'h2B, 5'd1, 5'd1, 16'hFFFC), 1'b0);
        check("mem[15]", tb_mem_rd(15), 32'h40);
        run_inst(enc_i(6'h23, 5'd1, 5'd2, 16'hFFFC), 1'b0);
        check("lw r2", dut.r[2], 32'h40);

        // Reset while a store sits in EXEC suppresses the write.
        run_inst(enc_i(6'h08, 5'd0, 5'd1, 16'h0080), 1'b0);
        bus.inst = enc_i(6'h2B, 5'd1, 5'd1, 16'd0);
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst gates mem_wen", 32'(bus.mem_wen), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("aborted sw mem[32]", tb_mem_rd(32), ref_mem_rd(32));
        check_arch("after sw abort");

        // Branches from PC=8.
        run_inst(32'd0, 1'b0);
        run_inst(32'd0, 1'b0);
        run_inst(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFE), 1'b0);
        check("beq taken pc", bus.inst_addr, 32'd4);
        run_inst(enc_i(6'h05, 5'd0, 5'd0, 16'd5), 1'b0);
        check("bne not taken pc", bus.inst_addr, 32'd8);

        // Jumps from PC=0x20.
        for (int i = 0; i < 6; i++) run_inst(32'd0, 1'b0);
        run_inst(enc_j(6'h03, 26'h10), 1'b0);
        check("jal r31", dut.r[31], 32'h24);
        check("jal pc", bus.inst_addr, 32'h40);
        run_inst(enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 1'b0);
        check("jr pc", bus.inst_addr, 32'h24);
        run_inst(enc_j(6'h3F, 26'h012_3456), 1'b0);
        check("unknown op pc", bus.inst_addr, 32'h28);

        // in_valid held with a different instruction while busy.
        run_inst(enc_i(6'h08, 5'd0, 5'd8, 16'h0011), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("busy idle out_valid", 32'(bus.out_valid), 32'd0);
        end
        check("busy r7", dut.r[7], 32'd0);
        check("busy r8", dut.r[8], 32'h11);
        check_arch("busy");

        // Randomized stream.
        for (int i = 0; i < 250; i++) run_inst(rand_inst(), $urandom_range(0, 3) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
